park_gate_sense: RTL and testbench
==================================

PARK_GATE_SENSE -- requirements
Module: park_gate_sense

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set the consecutive cycles a synchronized sensor level must hold before the debounced level changes.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum cycles allowed in any one passage state before abort.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sens_a  input  1  raw outer beam sensor (street side), asynchronous, high = beam broken.
REQ-006 sens_b  input  1  raw inner beam sensor (lot side), asynchronous, high = beam broken.
REQ-007 full  input  1  lot-full flag from downstream occupancy counter.
REQ-008 empty  input  1  lot-empty flag from downstream occupancy counter.
REQ-009 car_in  output  1  one-cycle pulse: completed entry; drives counter increment request.
REQ-010 car_out  output  1  one-cycle pulse: completed exit; drives counter decrement request.
REQ-011 reject  output  1  one-cycle pulse: passage refused (entry while full, exit while empty).
REQ-012 err  output  1  one-cycle pulse: illegal sensor sequence or timeout.
REQ-013 gate_open  output  1  level: entry barrier open (state IN_A, IN_AB or IN_B).
REQ-014 busy  output  1  level: state is not IDLE.

Function
REQ-015 Each sensor SHALL pass a 2-flop synchronizer, then a debouncer whose output (da, db) changes only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-016 FSM states SHALL be IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLR; all decisions use (da, db) only.
REQ-017 IDLE: da&~db -> IN_A, or WAIT_CLR with reject if full=1; ~da&db -> OUT_B, or WAIT_CLR with reject if empty=1; da&db -> WAIT_CLR with err.
REQ-018 IN_A: da&db -> IN_AB; ~da&~db -> IDLE (abort, no pulse); ~da&db -> WAIT_CLR with err.
REQ-019 IN_AB: ~da&db -> IN_B; da&~db -> IN_A (backing out); ~da&~db -> WAIT_CLR with err.
REQ-020 IN_B: ~da&~db -> IDLE with car_in; da&db -> IN_AB; da&~db -> WAIT_CLR with err.
REQ-021 OUT_B, OUT_BA, OUT_A SHALL mirror REQ-018..020 with a/b swapped, ending with car_out.
REQ-022 WAIT_CLR: ~da&~db -> IDLE; all other inputs hold; no pulses.
REQ-023 A dwell counter SHALL clear on every state change and in IDLE/WAIT_CLR; reaching TIMEOUT in any passage state SHALL force WAIT_CLR with err.
REQ-024 All outputs SHALL be registered; each pulse SHALL be high exactly one cycle, in the cycle after the triggering transition edge.
REQ-025 car_in, car_out, reject, err SHALL be mutually exclusive in every cycle.
REQ-026 full/empty SHALL be sampled only on leaving IDLE; changes mid-passage SHALL not affect the passage.
REQ-027 Timeout SHALL take priority over a sensor transition in the same cycle.

Reset
REQ-028 rst=1 SHALL force state IDLE, clear synchronizers, debouncers (da=db=0), dwell counter, and drive car_in=car_out=reject=err=gate_open=busy=0 on the next edge.
REQ-029 rst asserted mid-passage SHALL discard the passage with no pulse.

Structure
REQ-030 Package park_pkg SHALL hold the state enumeration and DEB_CYCLES/TIMEOUT defaults, shared with the occupancy counter.
REQ-031 Sub-module park_debounce (synchronizer + debouncer, one bit) SHALL be instantiated twice.

Verification
REQ-032 Entry: a=1; then b=1; then a=0; then b=0, each held 10 cycles, full=0 -> exactly one car_in pulse, gate_open high from IN_A through IN_B.
REQ-033 Exit with empty=0: b, b&a, a, none -> one car_out; same with empty=1 -> reject on first step, no car_out.
REQ-034 Entry with full=1 -> reject, state WAIT_CLR until both clear, no car_in.
REQ-035 Glitch: sens_a high 3 cycles (DEB_CYCLES=4) -> da unchanged, no state change.
REQ-036 a=1 held 70 cycles after debounce -> err at dwell 64, WAIT_CLR until a=0, then IDLE.
REQ-037 Back-out: a, a&b, a, none -> returns IDLE, no pulses; rst mid-IN_AB -> IDLE, no pulses.

Source files
------------

// File: rtl/park_gate_sense_pkg.sv
// Shared types and defaults for the parking gate sensing path and the occupancy counter.
// Holds the passage state encoding and the pulse bundle emitted on each decision.
package park_pkg;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IN_A,
        ST_IN_AB,
        ST_IN_B,
        ST_OUT_B,
        ST_OUT_BA,
        ST_OUT_A,
        ST_WAIT_CLR
    } park_state_e;

    typedef struct packed {
        logic car_in;
        logic car_out;
        logic reject;
        logic err;
    } park_pulse_t;

    function automatic logic is_passage(park_state_e s);
        return !(s inside {ST_IDLE, ST_WAIT_CLR});
    endfunction

    function automatic logic is_entry(park_state_e s);
        return s inside {ST_IN_A, ST_IN_AB, ST_IN_B};
    endfunction

endpackage

// File: rtl/park_gate_sense_if.sv
// Sensor, occupancy-flag and event signals between the gate sensing block and its neighbours.
interface park_gate_sense_if;
    logic sens_a;
    logic sens_b;
    logic full;
    logic empty;
    logic car_in;
    logic car_out;
    logic reject;
    logic err;
    logic gate_open;
    logic busy;

    modport master (
        output sens_a, sens_b, full, empty,
        input  car_in, car_out, reject, err, gate_open, busy
    );

    modport slave (
        input  sens_a, sens_b, full, empty,
        output car_in, car_out, reject, err, gate_open, busy
    );
endinterface

// File: rtl/park_gate_sense_debounce.sv
// One-bit 2-flop synchronizer followed by a consecutive-mismatch debouncer.
import park_pkg::*;

module park_debounce #(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Level flips on the DEB_CYCLES-th consecutive mismatching sample; any match restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 != r_level) begin
                if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
endmodule

// File: rtl/park_gate_sense.sv
// Two-beam parking gate passage tracker: debounces both beams, follows the entry/exit
// sequence and emits one-cycle count, reject and error pulses.
import park_pkg::*;

module park_gate_sense #(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    park_gate_sense_if.slave  bus
);
    localparam int DW = $clog2(TIMEOUT + 1);

    logic        w_da;
    logic        w_db;
    logic [1:0]  w_ab;
    logic        w_timeout;
    park_state_e w_next;
    park_pulse_t w_pls;

    park_state_e r_state;
    logic [DW-1:0] r_dwell;
    park_pulse_t r_pls;
    logic        r_gate_open;
    logic        r_busy;

    park_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk(clk), .rst(rst), .i_raw(bus.sens_a), .o_level(w_da)
    );

    park_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk(clk), .rst(rst), .i_raw(bus.sens_b), .o_level(w_db)
    );

    assign w_ab      = {w_da, w_db};
    assign w_timeout = is_passage(r_state) && (r_dwell == DW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        w_pls  = '0;
        // A stuck passage is abandoned even if the beams move in the same cycle.
        if (w_timeout) begin
            w_next    = ST_WAIT_CLR;
            w_pls.err = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    case (w_ab)
                        2'b10: if (bus.full)  begin w_next = ST_WAIT_CLR; w_pls.reject = 1'b1; end
                               else                 w_next = ST_IN_A;
                        2'b01: if (bus.empty) begin w_next = ST_WAIT_CLR; w_pls.reject = 1'b1; end
                               else                 w_next = ST_OUT_B;
                        2'b11: begin w_next = ST_WAIT_CLR; w_pls.err = 1'b1; end
                        default: ;
                    endcase
                end
                ST_IN_A: begin
                    case (w_ab)
                        2'b11: w_next = ST_IN_AB;
                        2'b00: w_next = ST_IDLE;
                        2'b01: begin w_next = ST_WAIT_CLR; w_pls.err = 1'b1; end
                        default: ;
                    endcase
                end
                ST_IN_AB: begin
                    case (w_ab)
                        2'b01: w_next = ST_IN_B;
                        2'b10: w_next = ST_IN_A;
                        2'b00: begin w_next = ST_WAIT_CLR; w_pls.err = 1'b1; end
                        default: ;
                    endcase
                end
                ST_IN_B: begin
                    case (w_ab)
                        2'b00: begin w_next = ST_IDLE; w_pls.car_in = 1'b1; end
                        2'b11: w_next = ST_IN_AB;
                        2'b10: begin w_next = ST_WAIT_CLR; w_pls.err = 1'b1; end
                        default: ;
                    endcase
                end
                ST_OUT_B: begin
                    case (w_ab)
                        2'b11: w_next = ST_OUT_BA;
                        2'b00: w_next = ST_IDLE;
                        2'b10: begin w_next = ST_WAIT_CLR; w_pls.err = 1'b1; end
                        default: ;
                    endcase
                end
                ST_OUT_BA: begin
                    case (w_ab)
                        2'b10: w_next = ST_OUT_A;
                        2'b01: w_next = ST_OUT_B;
                        2'b00: begin w_next = ST_WAIT_CLR; w_pls.err = 1'b1; end
                        default: ;
                    endcase
                end
                ST_OUT_A: begin
                    case (w_ab)
                        2'b00: begin w_next = ST_IDLE; w_pls.car_out = 1'b1; end
                        2'b11: w_next = ST_OUT_BA;
                        2'b01: begin w_next = ST_WAIT_CLR; w_pls.err = 1'b1; end
                        default: ;
                    endcase
                end
                ST_WAIT_CLR: if (w_ab == 2'b00) w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dwell     <= '0;
            r_pls       <= '0;
            r_gate_open <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_dwell     <= (w_next != r_state || !is_passage(r_state)) ? '0 : r_dwell + 1'b1;
            r_pls       <= w_pls;
            r_gate_open <= is_entry(w_next);
            r_busy      <= (w_next != ST_IDLE);
        end
    end

    assign bus.car_in    = r_pls.car_in;
    assign bus.car_out   = r_pls.car_out;
    assign bus.reject    = r_pls.reject;
    assign bus.err       = r_pls.err;
    assign bus.gate_open = r_gate_open;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_park_gate_sense.sv
// Bench for park_gate_sense: directed step table, hand sequences and a randomized run
// compared each cycle against a passage-position reference model.
module tb_park_gate_sense;
    localparam int DEB = 4;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    park_gate_sense_if bus ();

    park_gate_sense #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;
    int c_in, c_out, c_rej, c_err, c_busy;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Passage is tracked as a direction and a position 1..3 along the lead/trail pattern
    // (lead only, both, trail only); 0 and 4 both mean "no beam".
    bit qa[$], qb[$];
    bit m_da, m_db;
    int m_mode, m_dir, m_pos, m_age;   // mode: 0 idle, 1 passage, 2 wait-for-clear
    bit e_in, e_out, e_rej, e_err, e_gate, e_busy;

    function automatic bit [1:0] pcode(int p);
        case (p)
            1: return 2'b10;
            2: return 2'b11;
            3: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit all_differ(bit q[$], bit lvl);
        for (int i = 0; i < DEB; i++) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit [1:0] rd;
        bit fa, fb;
        if (rst) begin
            qa.delete(); qb.delete();
            for (int i = 0; i < DEB + 2; i++) begin qa.push_back(1'b0); qb.push_back(1'b0); end
            m_da = 0; m_db = 0; m_mode = 0; m_dir = 0; m_pos = 0; m_age = 0;
            {e_in, e_out, e_rej, e_err, e_gate, e_busy} = '0;
        end else begin
            qa.push_back(bus.sens_a); void'(qa.pop_front());
            qb.push_back(bus.sens_b); void'(qb.pop_front());
            {e_in, e_out, e_rej, e_err} = '0;
            if (m_mode == 0) begin
                if (m_da && !m_db) begin
                    if (bus.full) begin m_mode = 2; e_rej = 1; end
                    else begin m_mode = 1; m_dir = 0; m_pos = 1; m_age = 0; end
                end else if (!m_da && m_db) begin
                    if (bus.empty) begin m_mode = 2; e_rej = 1; end
                    else begin m_mode = 1; m_dir = 1; m_pos = 1; m_age = 0; end
                end else if (m_da && m_db) begin
                    m_mode = 2; e_err = 1;
                end
            end else if (m_mode == 2) begin
                if (!m_da && !m_db) m_mode = 0;
            end else begin
                m_age++;
                rd = (m_dir == 0) ? {m_da, m_db} : {m_db, m_da};
                if (m_age == TMO) begin
                    m_mode = 2; e_err = 1;
                end else if (rd == pcode(m_pos)) begin
                end else if (rd == pcode(m_pos + 1)) begin
                    if (m_pos == 3) begin
                        m_mode = 0;
                        if (m_dir == 0) e_in = 1; else e_out = 1;
                    end else begin m_pos++; m_age = 0; end
                end else if (rd == pcode(m_pos - 1)) begin
                    if (m_pos == 1) m_mode = 0; else begin m_pos--; m_age = 0; end
                end else begin
                    m_mode = 2; e_err = 1;
                end
            end
            fa = all_differ(qa, m_da);
            fb = all_differ(qb, m_db);
            if (fa) m_da = ~m_da;
            if (fb) m_db = ~m_db;
            e_gate = (m_mode == 1) && (m_dir == 0);
            e_busy = (m_mode != 0);
        end
    end

    // Per-cycle model comparison and pulse/busy counters for the directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            nchk++;
            if ({bus.car_in, bus.car_out, bus.reject, bus.err, bus.gate_open, bus.busy} !==
                {e_in, e_out, e_rej, e_err, e_gate, e_busy}) begin
                nerr++;
                if (nerr <= 20)
                    $display("FAIL model t=%0t: got in/out/rej/err/gate/busy=%b%b%b%b%b%b, expected %b%b%b%b%b%b",
                             $time, bus.car_in, bus.car_out, bus.reject, bus.err, bus.gate_open, bus.busy,
                             e_in, e_out, e_rej, e_err, e_gate, e_busy);
            end
            nchk++;
            if ($countones({bus.car_in, bus.car_out, bus.reject, bus.err}) > 1) begin
                nerr++;
                $display("FAIL pulse_exclusive t=%0t: got %b, expected at most one high",
                         $time, {bus.car_in, bus.car_out, bus.reject, bus.err});
            end
            c_in   += int'(bus.car_in);
            c_out  += int'(bus.car_out);
            c_rej  += int'(bus.reject);
            c_err  += int'(bus.err);
            c_busy += int'(bus.busy);
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        string nm;
        bit    a, b, f, e;
        int    cyc;
        int    ei, eo, er, ee;
        bit    eb, eg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, bit a, bit b, bit f, bit e, int cyc,
                                int ei, int eo, int er, int ee, bit eb, bit eg);
        vec_t v;
        v.nm = nm; v.a = a; v.b = b; v.f = f; v.e = e; v.cyc = cyc;
        v.ei = ei; v.eo = eo; v.er = er; v.ee = ee; v.eb = eb; v.eg = eg;
        return v;
    endfunction

    task automatic clr_cnt();
        c_in = 0; c_out = 0; c_rej = 0; c_err = 0; c_busy = 0;
    endtask

    task automatic drive(bit a, bit b, bit f, bit e, int n);
        @(negedge clk);
        bus.sens_a = a; bus.sens_b = b; bus.full = f; bus.empty = e;
        clr_cnt();
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.sens_a = 0; bus.sens_b = 0; bus.full = 0; bus.empty = 0;
        clr_cnt();

        tbl.push_back(mk("entry_a",     1,0,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("entry_ab",    1,1,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("entry_b",     0,1,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("entry_done",  0,0,0,0,10, 1,0,0,0, 0,0));
        tbl.push_back(mk("exit_b",      0,1,0,0,10, 0,0,0,0, 1,0));
        tbl.push_back(mk("exit_ba",     1,1,0,0,10, 0,0,0,0, 1,0));
        tbl.push_back(mk("exit_a",      1,0,0,0,10, 0,0,0,0, 1,0));
        tbl.push_back(mk("exit_done",   0,0,0,0,10, 0,1,0,0, 0,0));
        tbl.push_back(mk("exit_empty",  0,1,0,1,10, 0,0,1,0, 1,0));
        tbl.push_back(mk("exitE_ba",    1,1,0,1,10, 0,0,0,0, 1,0));
        tbl.push_back(mk("exitE_a",     1,0,0,1,10, 0,0,0,0, 1,0));
        tbl.push_back(mk("exitE_clr",   0,0,0,1,10, 0,0,0,0, 0,0));
        tbl.push_back(mk("entry_full",  1,0,1,0,10, 0,0,1,0, 1,0));
        tbl.push_back(mk("entryF_ab",   1,1,1,0,10, 0,0,0,0, 1,0));
        tbl.push_back(mk("entryF_b",    0,1,1,0,10, 0,0,0,0, 1,0));
        tbl.push_back(mk("entryF_clr",  0,0,1,0,10, 0,0,0,0, 0,0));
        tbl.push_back(mk("back_a",      1,0,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("back_ab",     1,1,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("back_a2",     1,0,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("back_clr",    0,0,0,0,10, 0,0,0,0, 0,0));
        tbl.push_back(mk("both_idle",   1,1,0,0,10, 0,0,0,1, 1,0));
        tbl.push_back(mk("both_clr",    0,0,0,0,10, 0,0,0,0, 0,0));
        tbl.push_back(mk("skip_a",      1,0,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("skip_b",      0,1,0,0,10, 0,0,0,1, 1,0));
        tbl.push_back(mk("skip_clr",    0,0,0,0,10, 0,0,0,0, 0,0));
        tbl.push_back(mk("midfull_a",   1,0,0,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("midfull_ab",  1,1,1,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("midfull_b",   0,1,1,0,10, 0,0,0,0, 1,1));
        tbl.push_back(mk("midfull_end", 0,0,1,0,10, 1,0,0,0, 0,0));
        tbl.push_back(mk("timeout",     1,0,0,0,80, 0,0,0,1, 1,0));
        tbl.push_back(mk("timeout_clr", 0,0,0,0,10, 0,0,0,0, 0,0));

        repeat (2) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("reset_outs", 32'({bus.car_in, bus.car_out, bus.reject, bus.err, bus.gate_open, bus.busy}), 32'd0);
        rst = 0;

        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].e, tbl[i].cyc);
            chk({tbl[i].nm, "/pulses"}, {8'(c_in), 8'(c_out), 8'(c_rej), 8'(c_err)},
                {8'(tbl[i].ei), 8'(tbl[i].eo), 8'(tbl[i].er), 8'(tbl[i].ee)});
            chk({tbl[i].nm, "/levels"}, 32'({bus.busy, bus.gate_open}), 32'({tbl[i].eb, tbl[i].eg}));
        end

        // Glitch shorter than the debounce window must leave the FSM idle.
        @(negedge clk);
        bus.sens_a = 1; clr_cnt();
        repeat (DEB - 1) @(negedge clk);
        bus.sens_a = 0;
        repeat (12) @(negedge clk);
        chk("glitch/busy_cycles", 32'(c_busy), 32'd0);
        chk("glitch/pulses", 32'(c_in + c_out + c_rej + c_err), 32'd0);

        // Reset in the middle of IN_AB discards the passage.
        drive(1, 0, 0, 0, 10);
        drive(1, 1, 0, 0, 10);
        chk("rstmid/in_ab", 32'({bus.busy, bus.gate_open}), 32'b11);
        @(negedge clk);
        rst = 1; bus.sens_a = 0; bus.sens_b = 0; clr_cnt();
        repeat (2) @(negedge clk);
        chk("rstmid/outs", 32'({bus.car_in, bus.car_out, bus.reject, bus.err, bus.gate_open, bus.busy}), 32'd0);
        rst = 0;
        repeat (12) @(negedge clk);
        chk("rstmid/after", 32'({c_in + c_out + c_rej + c_err, 1'b0, bus.busy}), 32'd0);

        // Randomized segments with occasional long holds and resets.
        for (int s = 0; s < 400; s++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            bus.sens_a = 1'($urandom);
            bus.sens_b = 1'($urandom);
            bus.full   = ($urandom_range(0, 3) == 0);
            bus.empty  = ($urandom_range(0, 3) == 0);
            if (rst) begin
                @(negedge clk);
                rst = 0;
            end
            if ($urandom_range(0, 29) == 0) repeat (TMO + 10) @(negedge clk);
            else repeat ($urandom_range(0, 11)) @(negedge clk);
        end
        @(negedge clk);
        bus.sens_a = 0; bus.sens_b = 0;
        repeat (20) @(negedge clk);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
